udp_tx_stream: RTL and testbench

Parametrised UDP/IPv4 transmit framer. It accepts a variable-length payload of 32-bit words over a valid/ready stream and buffers one frame. It then requests the shared TX arbiter and serves header and payload bytes to the MAC by byte address. Addresses and ports are parameters, lengths are computed per frame, and the IP checksum is computed with correct end-around carry.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/udp_payload_buf.sv | 20 ++
 rtl/udp_tx_stream.sv | 146 ++++++++++++++
 tb/tb_udp_tx_stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet/IPv4/UDP framing constants, framer state encoding and checksum fold
package eth_pkg;
    localparam int ETH_HDR     = 14;
    localparam int IP_HDR      = 20;
    localparam int UDP_HDR     = 8;
    localparam int PAYLOAD_OFS = ETH_HDR + IP_HDR + UDP_HDR;
    localparam int MIN_FRAME   = 60;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        FILL = 5'b00010,
        ARB  = 5'b00100,
        HDR  = 5'b01000,
        DATA = 5'b10000
    } state_t;
    // Two end-around folds always suffice for a sum of ten 16-bit words
    function automatic logic [15:0] oc_fold(input logic [19:0] s);
        logic [19:0] t;
        t = {4'b0, s[15:0]} + {16'b0, s[19:16]};
        t = {4'b0, t[15:0]} + {16'b0, t[19:16]};
        return t[15:0];
    endfunction
endpackage

// File: rtl/udp_payload_buf.sv
// udp_payload_buf: simple dual-port payload RAM with 1-cycle registered read
module udp_payload_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/udp_tx_stream.sv
// udp_tx_stream: buffers one UDP payload frame and serves header+payload bytes to the MAC by address
module udp_tx_stream
    import eth_pkg::*;
#(
    parameter logic [47:0] MY_HWADDR = 48'h985aebdd1c65,
    parameter logic [47:0] RX_HWADDR = 48'h985aebdd1c64,
    parameter logic [31:0] MY_IP     = 32'hc0a80205,
    parameter logic [31:0] RX_IP     = 32'hc0a80202,
    parameter logic [15:0] SRC_PORT  = 16'h4e50,
    parameter logic [15:0] DST_PORT  = 16'h4e50,
    parameter logic [7:0]  TTL       = 8'h40,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        tx_req,
    output logic [10:0] tx_count,
    input  logic        tx_grant,
    input  logic [10:0] tx_addr,
    input  logic        tx_adv,
    input  logic        tx_last,
    output logic [7:0]  tx_data,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        busy,
    output logic [15:0] pkt_id
);
    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int NW = $clog2(MAX_WORDS) + 1;

    state_t        r_state;
    logic [NW-1:0] r_n;
    logic [15:0]   r_pkt_id;
    logic          r_tx_req;
    logic [10:0]   r_tx_count;
    logic [15:0]   r_csum;
    logic [7:0]    r_byte;

    logic          w_beat;
    logic          w_tx_on;
    logic [NW-1:0] w_n_next;
    logic [10:0]   w_len4;
    logic [10:0]   w_len4_next;
    logic [10:0]   w_frame_next;
    logic [10:0]   w_cnt_next;
    logic [15:0]   w_tl_next;
    logic [15:0]   w_total_len;
    logic [15:0]   w_udp_len;
    logic [335:0]  w_hdr;
    logic [10:0]   w_off;
    logic [10:0]   w_ra;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_rdata;
    logic [7:0]    w_byte;

    function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id);
        logic [19:0] s;
        s = 20'h04500 + 20'(tl) + 20'(id) + 20'({TTL, IP_PROTO_UDP})
          + 20'(MY_IP[31:16]) + 20'(MY_IP[15:0]) + 20'(RX_IP[31:16]) + 20'(RX_IP[15:0]);
        return ~oc_fold(s);
    endfunction

    assign w_beat       = s_valid & s_ready;
    assign w_tx_on      = (r_state == HDR) | (r_state == DATA);
    assign w_n_next     = r_n + 1'b1;
    assign w_len4       = 11'({r_n, 2'b00});
    assign w_len4_next  = 11'({w_n_next, 2'b00});
    assign w_frame_next = 11'(PAYLOAD_OFS) + w_len4_next;
    assign w_cnt_next   = (w_frame_next < 11'(MIN_FRAME)) ? 11'(MIN_FRAME) : w_frame_next;
    assign w_tl_next    = 16'(IP_HDR + UDP_HDR) + 16'(w_len4_next);
    assign w_total_len  = 16'(IP_HDR + UDP_HDR) + 16'(w_len4);
    assign w_udp_len    = 16'(UDP_HDR) + 16'(w_len4);

    assign w_hdr = {RX_HWADDR, MY_HWADDR, ETHERTYPE_IPV4, 8'h45, 8'h00, w_total_len,
                    r_pkt_id, 16'h0000, TTL, IP_PROTO_UDP, r_csum, MY_IP, RX_IP,
                    SRC_PORT, DST_PORT, w_udp_len, 16'h0000};

    // Read one address ahead on a strobe so the word is ready for a back-to-back strobe
    assign w_ra    = tx_adv ? tx_addr + 11'd1 : tx_addr;
    assign w_raddr = AW'((w_ra - 11'(PAYLOAD_OFS)) >> 2);
    assign w_off   = tx_addr - 11'(PAYLOAD_OFS);
    assign w_byte  = (tx_addr < 11'(PAYLOAD_OFS)) ? w_hdr[335 - 8*int'(tx_addr[5:0]) -: 8] :
                     (w_off < w_len4) ? w_rdata[31 - 8*int'(w_off[1:0]) -: 8] : 8'h00;

    udp_payload_buf #(.DEPTH(MAX_WORDS), .AW(AW)) u_buf (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr (r_n[AW-1:0]),
        .i_wdata (s_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_pkt_id   <= '0;
            r_tx_req   <= 1'b0;
            r_tx_count <= '0;
            r_csum     <= '0;
            r_byte     <= '0;
        end else begin
            case (r_state)
                IDLE, FILL: if (w_beat) begin
                    r_n     <= w_n_next;
                    r_state <= FILL;
                    if (s_last || w_n_next == NW'(MAX_WORDS)) begin
                        r_state    <= ARB;
                        r_tx_req   <= 1'b1;
                        r_tx_count <= w_cnt_next;
                        r_csum     <= ip_csum(w_tl_next, r_pkt_id);
                    end
                end
                ARB: if (tx_grant) begin
                    r_state    <= HDR;
                    r_tx_req   <= 1'b0;
                    r_tx_count <= '0;
                end
                HDR: if (tx_last) begin
                    r_state  <= IDLE;
                    r_n      <= '0;
                    r_pkt_id <= r_pkt_id + 16'd1;
                end else if (tx_adv && tx_addr == 11'(PAYLOAD_OFS - 1)) begin
                    r_state <= DATA;
                end
                DATA: if (tx_last) begin
                    r_state  <= IDLE;
                    r_n      <= '0;
                    r_pkt_id <= r_pkt_id + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
            if (tx_adv && w_tx_on) r_byte <= w_byte;
        end
    end

    assign tx_req   = r_tx_req;
    assign tx_count = r_tx_count;
    assign tx_data  = w_tx_on ? r_byte : 8'h00;
    assign s_ready  = (r_state == IDLE) | (r_state == FILL);
    assign busy     = r_state != IDLE;
    assign pkt_id   = r_pkt_id;
endmodule

// File: tb/tb_udp_tx_stream.sv
// tb_udp_tx_stream: randomized frames checked against a byte-level frame model
module tb_udp_tx_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_req, tx_grant = 1'b0, tx_adv = 1'b0, tx_last = 1'b0;
    logic [10:0] tx_count, tx_addr = '0;
    logic [7:0]  tx_data;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready, busy;
    logic [31:0] s_data = '0;
    logic [15:0] pkt_id;
    logic        tx_req4, tx_grant4 = 1'b0, tx_adv4 = 1'b0, tx_last4 = 1'b0;
    logic [10:0] tx_count4, tx_addr4 = '0;
    logic [7:0]  tx_data4;
    logic        s_valid4 = 1'b0, s_last4 = 1'b0, s_ready4, busy4;
    logic [31:0] s_data4 = '0;
    logic [15:0] pkt_id4;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] words[64];
    logic [7:0]  exp_b[1100];
    logic [7:0]  rx[1100];
    int          exp_len;
    int          wp;
    logic [15:0] exp_id;
    logic [10:0] got_count;

    always #5 clk = ~clk;

    udp_tx_stream dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_count(tx_count), .tx_grant(tx_grant),
        .tx_addr(tx_addr), .tx_adv(tx_adv), .tx_last(tx_last), .tx_data(tx_data),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .busy(busy), .pkt_id(pkt_id)
    );

    udp_tx_stream #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .tx_req(tx_req4), .tx_count(tx_count4), .tx_grant(tx_grant4),
        .tx_addr(tx_addr4), .tx_adv(tx_adv4), .tx_last(tx_last4), .tx_data(tx_data4),
        .s_valid(s_valid4), .s_data(s_data4), .s_last(s_last4), .s_ready(s_ready4),
        .busy(busy4), .pkt_id(pkt_id4)
    );

    function automatic void put(int nb, logic [63:0] v);
        for (int i = nb - 1; i >= 0; i--) begin
            exp_b[wp] = v[8*i +: 8];
            wp++;
        end
    endfunction

    // Expected wire image of a frame of n words with IP ID id
    function automatic void build_expected(int n, logic [15:0] id);
        logic [15:0] hw[10];
        int s;
        hw = '{16'h4500, 16'(28 + 4*n), id, 16'h0000, 16'h4011, 16'h0000,
               16'hc0a8, 16'h0205, 16'hc0a8, 16'h0202};
        s = 0;
        foreach (hw[i]) s += int'(hw[i]);
        while (s > 'hffff) s = (s & 'hffff) + (s >> 16);
        exp_len = (42 + 4*n < 60) ? 60 : 42 + 4*n;
        for (int a = 0; a < exp_len; a++) exp_b[a] = 8'h00;
        wp = 0;
        put(6, 64'h985aebdd1c64); put(6, 64'h985aebdd1c65); put(2, 64'h0800); put(2, 64'h4500);
        put(2, 64'(28 + 4*n)); put(2, 64'(id)); put(2, 64'h0); put(2, 64'h4011);
        put(2, 64'(~s[15:0])); put(4, 64'hc0a80205); put(4, 64'hc0a80202);
        put(2, 64'h4e50); put(2, 64'h4e50); put(2, 64'(8 + 4*n)); put(2, 64'h0);
        for (int i = 0; i < n; i++) put(4, 64'(words[i]));
    endfunction

    task automatic send(int n, bit last, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(2) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = last && (i == n - 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic receive(int n, bit gaps);
        int t = 0;
        build_expected(n, exp_id);
        while (tx_req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (tx_req !== 1'b1) begin
            $display("FAIL tx_req wait: got %b want 1", tx_req);
            return;
        end
        passed++;
        got_count = tx_count;
        checks++;
        if (tx_count !== 11'(exp_len)) $display("FAIL tx_count: got %0d want %0d", tx_count, exp_len);
        else passed++;
        tx_grant = 1'b1;
        @(negedge clk);
        tx_grant = 1'b0;
        for (int a = 0; a < exp_len; a++) begin
            if (gaps && $urandom_range(3) == 0) begin
                tx_addr = 11'(a);
                @(negedge clk);
            end
            tx_addr = 11'(a);
            tx_adv  = 1'b1;
            @(negedge clk);
            tx_adv  = 1'b0;
            rx[a]   = tx_data;
            checks++;
            if (tx_data !== exp_b[a]) $display("FAIL byte %0d: got %h want %h", a, tx_data, exp_b[a]);
            else passed++;
        end
        tx_last = 1'b1;
        @(negedge clk);
        tx_last = 1'b0;
        exp_id++;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || tx_data !== 8'h00 || pkt_id !== exp_id)
            $display("FAIL frame end: busy %b s_ready %b tx_data %h pkt_id %h, want 0 1 00 %h",
                     busy, s_ready, tx_data, pkt_id, exp_id);
        else passed++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_id = 16'h0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_req !== 1'b0) $display("FAIL reset tx_req: got %b want 0", tx_req); else passed++;
        checks++; if (tx_count !== 11'd0) $display("FAIL reset tx_count: got %0d want 0", tx_count); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (s_ready !== 1'b1) $display("FAIL reset s_ready: got %b want 1", s_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        checks++; if (pkt_id !== 16'h0) $display("FAIL reset pkt_id: got %h want 0000", pkt_id); else passed++;
        checks++; if (s_ready4 !== 1'b1 || busy4 !== 1'b0) $display("FAIL reset dut4: s_ready %b busy %b want 1 0", s_ready4, busy4); else passed++;
        tx_grant = 1'b1; tx_adv = 1'b1; tx_addr = 11'd5;
        @(negedge clk);
        tx_grant = 1'b0; tx_adv = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_data !== 8'h00) $display("FAIL idle grant/adv: busy %b tx_data %h want 0 00", busy, tx_data); else passed++;
    endtask

    task automatic test_single();
        words[0] = 32'h01020304;
        send(1, 1'b1, 1'b0);
        receive(1, 1'b0);
        checks++; if (got_count !== 11'd60) $display("FAIL single count: got %0d want 60", got_count); else passed++;
        checks++; if ({rx[16], rx[17]} !== 16'h0020) $display("FAIL single total_len: got %h want 0020", {rx[16], rx[17]}); else passed++;
        checks++; if ({rx[24], rx[25]} !== 16'hf575) $display("FAIL single chksum: got %h want f575", {rx[24], rx[25]}); else passed++;
        checks++; if ({rx[38], rx[39]} !== 16'h000c) $display("FAIL single udp_len: got %h want 000c", {rx[38], rx[39]}); else passed++;
        checks++; if ({rx[42], rx[43], rx[44], rx[45]} !== 32'h01020304) $display("FAIL single payload: got %h want 01020304", {rx[42], rx[43], rx[44], rx[45]}); else passed++;
    endtask

    task automatic test_eight();
        for (int i = 0; i < 8; i++) words[i] = 32'(i);
        send(8, 1'b1, 1'b1);
        receive(8, 1'b1);
        checks++; if (got_count !== 11'd74) $display("FAIL eight count: got %0d want 74", got_count); else passed++;
        checks++; if ({rx[16], rx[17]} !== 16'h003c) $display("FAIL eight total_len: got %h want 003c", {rx[16], rx[17]}); else passed++;
        checks++; if ({rx[38], rx[39]} !== 16'h0028) $display("FAIL eight udp_len: got %h want 0028", {rx[38], rx[39]}); else passed++;
        checks++; if (rx[73] !== 8'h07) $display("FAIL eight byte73: got %h want 07", rx[73]); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        words[0] = 32'h01020304;
        send(1, 1'b1, 1'b0);
        receive(1, 1'b0);
        checks++; if ({rx[24], rx[25]} !== 16'hf575) $display("FAIL b2b chksum0: got %h want f575", {rx[24], rx[25]}); else passed++;
        send(1, 1'b1, 1'b0);
        receive(1, 1'b0);
        checks++; if ({rx[24], rx[25]} !== 16'hf574) $display("FAIL b2b chksum1: got %h want f574", {rx[24], rx[25]}); else passed++;
        checks++; if ({rx[18], rx[19]} !== 16'h0001) $display("FAIL b2b ip id: got %h want 0001", {rx[18], rx[19]}); else passed++;
        checks++; if (got_count !== 11'd60) $display("FAIL b2b count: got %0d want 60", got_count); else passed++;
    endtask

    task automatic test_grant_delay();
        int bad = 0;
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        send(5, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            s_valid = ($urandom_range(3) == 0);
            s_data  = $urandom;
            s_last  = 1'($urandom_range(1));
            tx_adv  = 1'($urandom_range(1));
            tx_addr = 11'($urandom_range(59));
            @(negedge clk);
            if (tx_req !== 1'b1 || tx_count !== 11'd62 || s_ready !== 1'b0 || tx_data !== 8'h00) bad++;
        end
        s_valid = 1'b0; s_last = 1'b0; tx_adv = 1'b0;
        checks++; if (bad != 0) $display("FAIL grant wait: %0d bad cycles, want 0", bad); else passed++;
        receive(5, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = (f == 0) ? 64 : int'($urandom_range(64, 1));
            bit last = (f == 0) ? 1'b0 : (n < 64) ? 1'b1 : 1'($urandom_range(1));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            send(n, last, 1'b1);
            receive(n, 1'b1);
        end
    endtask

    task automatic test_implicit_last();
        int bad = 0;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            s_valid4 = 1'b1;
            s_data4  = words[i];
            @(negedge clk);
        end
        s_valid4 = 1'b0;
        checks++; if (s_ready4 !== 1'b0) $display("FAIL implicit s_ready: got %b want 0", s_ready4); else passed++;
        checks++; if (tx_req4 !== 1'b1) $display("FAIL implicit tx_req: got %b want 1", tx_req4); else passed++;
        checks++; if (tx_count4 !== 11'd60) $display("FAIL implicit count: got %0d want 60", tx_count4); else passed++;
        s_valid4 = 1'b1; s_data4 = ~words[0]; s_last4 = 1'b1;
        repeat (2) @(negedge clk);
        s_valid4 = 1'b0; s_last4 = 1'b0;
        checks++; if (tx_count4 !== 11'd60 || s_ready4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL extra beat: count %0d s_ready %b busy %b want 60 0 1", tx_count4, s_ready4, busy4); else passed++;
        build_expected(4, 16'h0);
        tx_grant4 = 1'b1;
        @(negedge clk);
        tx_grant4 = 1'b0;
        for (int a = 0; a < 60; a++) begin
            tx_addr4 = 11'(a);
            tx_adv4  = 1'b1;
            @(negedge clk);
            tx_adv4  = 1'b0;
            if (tx_data4 !== exp_b[a]) bad++;
        end
        checks++; if (bad != 0) $display("FAIL implicit frame: %0d wrong bytes, want 0", bad); else passed++;
        tx_last4 = 1'b1;
        @(negedge clk);
        tx_last4 = 1'b0;
        checks++; if (pkt_id4 !== 16'h1 || busy4 !== 1'b0) $display("FAIL implicit end: pkt_id %h busy %b want 0001 0", pkt_id4, busy4); else passed++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        send(3, 1'b1, 1'b0);
        while (tx_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        tx_grant = 1'b1;
        @(negedge clk);
        tx_grant = 1'b0;
        for (int a = 0; a <= 30; a++) begin
            tx_addr = 11'(a);
            tx_adv  = 1'b1;
            @(negedge clk);
        end
        tx_adv = 1'b0;
        checks++; if (busy !== 1'b1 || pkt_id === 16'h0) $display("FAIL pre-reset: busy %b pkt_id %h want 1 nonzero", busy, pkt_id); else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL mid reset busy: got %b want 0", busy); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL mid reset tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (s_ready !== 1'b1) $display("FAIL mid reset s_ready: got %b want 1", s_ready); else passed++;
        checks++; if (pkt_id !== 16'h0) $display("FAIL mid reset pkt_id: got %h want 0000", pkt_id); else passed++;
        checks++; if (tx_req !== 1'b0) $display("FAIL mid reset tx_req: got %b want 0", tx_req); else passed++;
        reset = 1'b0;
        exp_id = 16'h0;
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        send(6, 1'b1, 1'b1);
        receive(6, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_eight();
        test_back_to_back();
        test_grant_delay();
        test_random();
        test_implicit_last();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
